cpu_seq: RTL and testbench

CPU_SEQ -- requirements
Module: cpu_seq

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_seq_accum_alu.sv | 24 ++
 rtl/cpu_seq.sv | 118 +++++++++++
 tb/tb_cpu_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_seq accumulator sequencer: opcodes, instruction
// layout and FSM state encoding.
package cpu_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned ARG_W  = 6;
  localparam int unsigned WORD_W = OP_W + ARG_W;
  localparam int unsigned ACC_W  = 8;

  localparam logic [OP_W-1:0] OP_HLT = 2'b00;
  localparam logic [OP_W-1:0] OP_INC = 2'b01;
  localparam logic [OP_W-1:0] OP_JMP = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPRD   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } instr_t;

endpackage

// File: rtl/cpu_seq_accum_alu.sv
// Accumulator adder: accum + opnd for ADD, accum + 1 otherwise, with 9-bit carry-out.
module accum_alu
  import cpu_pkg::*;
(
  input  logic [ACC_W-1:0] accum,
  input  logic [ACC_W-1:0] opnd,
  input  logic [OP_W-1:0]  op,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, accum} + {{ACC_W{1'b0}}, 1'b1};
    if (op == OP_ADD) begin
      full = {1'b0, accum} + {1'b0, opnd};
    end
  end

  assign sum   = full[ACC_W-1:0];
  assign carry = full[ACC_W];

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle accumulator sequencer fetching 8-bit instructions from a strobed ROM.
// Optional feature: define CPU_SEQ_JMP_EN to execute op 10 as JMP (otherwise NOP).
module cpu_seq
  import cpu_pkg::*;
#(
  parameter logic [ARG_W-1:0] PC_RST = 6'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] rom_data,
  output logic [ARG_W-1:0]  rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  output logic [ACC_W-1:0]  accum,
  output logic              carry,
  output logic [ARG_W-1:0]  pc,
  output logic              halted
);

  state_t            state;
  state_t            state_nx;
  instr_t            ir;
  logic [ACC_W-1:0]  opnd;
  logic [ACC_W-1:0]  alu_sum;
  logic              alu_carry;

  accum_alu u_alu (
    .accum (accum),
    .opnd  (opnd),
    .op    (ir.op),
    .sum   (alu_sum),
    .carry (alu_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; strobed states always fall into an unstrobed one
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: begin
        if (ir.op == OP_HLT) begin
          state_nx = ST_HALT;
        end else if (ir.op == OP_ADD) begin
          state_nx = ST_OPRD;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_OPRD:   state_nx = ST_EXEC;
      ST_EXEC:   state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    rom_addr = pc;
    rom_read = 1'b0;
    rom_ena  = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_FETCH: begin
        rom_read = 1'b1;
        rom_ena  = 1'b1;
      end
      ST_OPRD: begin
        rom_addr = ir.arg;
        rom_read = 1'b1;
        rom_ena  = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  // Datapath registers: ir/opnd capture on strobed cycles, update on EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= PC_RST;
      accum <= '0;
      carry <= 1'b0;
      ir    <= '0;
      opnd  <= '0;
    end else begin
      case (state)
        ST_FETCH: ir   <= instr_t'(rom_data);
        ST_OPRD:  opnd <= rom_data;
        ST_EXEC: begin
          pc <= pc + ARG_W'(1);
          case (ir.op)
            OP_INC, OP_ADD: begin
              accum <= alu_sum;
              carry <= alu_carry;
            end
`ifdef CPU_SEQ_JMP_EN
            OP_JMP: pc <= ir.arg;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: instruction-level reference model expanded into
// a per-cycle expected trace, plus directed literal checks.
module tb_cpu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rom [64];

  logic [5:0] addr0, addr1, pc0, pc1;
  logic       rd0, en0, rd1, en1, cy0, cy1, h0, h1;
  logic [7:0] acc0, acc1, data0, data1;

  always #5 clk = ~clk;

  // ROM drives garbage unless strobed, so mistimed captures show up
  assign data0 = (rd0 && en0) ? rom[addr0] : 8'h5A;
  assign data1 = (rd1 && en1) ? rom[addr1] : 8'h5A;

  cpu_seq dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(data0),
    .rom_addr(addr0), .rom_read(rd0), .rom_ena(en0),
    .accum(acc0), .carry(cy0), .pc(pc0), .halted(h0)
  );

  cpu_seq #(.PC_RST(6'd63)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(data1),
    .rom_addr(addr1), .rom_read(rd1), .rom_ena(en1),
    .accum(acc1), .carry(cy1), .pc(pc1), .halted(h1)
  );

  typedef struct packed {
    logic [5:0] addr;
    logic       stb;
    logic [7:0] acc;
    logic       cy;
    logic [5:0] pc;
    logic       halt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   sel   = 1'b0;
  bit   prev_stb = 1'b0;

  function automatic exp_t mk(logic [5:0] a, logic s, logic [7:0] ac, logic c,
                              logic [5:0] p, logic h);
    exp_t e;
    e.addr = a; e.stb = s; e.acc = ac; e.cy = c; e.pc = p; e.halt = h;
    return e;
  endfunction

  task automatic check(string name, exp_t e);
    exp_t o;
    logic rd, en;
    rd = sel ? rd1 : rd0;
    en = sel ? en1 : en0;
    o  = sel ? mk(addr1, rd1, acc1, cy1, pc1, h1) : mk(addr0, rd0, acc0, cy0, pc0, h0);
    tests++;
    if (o !== e || rd !== en || (prev_stb && rd)) begin
      fails++;
      $display("FAIL %s: got addr=%0d rd=%b ena=%b acc=%0d cy=%b pc=%0d halt=%b, want addr=%0d stb=%b acc=%0d cy=%b pc=%0d halt=%b",
               name, o.addr, rd, en, o.acc, o.cy, o.pc, o.halt,
               e.addr, e.stb, e.acc, e.cy, e.pc, e.halt);
    end
    prev_stb = rd;
  endtask

  task automatic lit(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Instruction-level interpreter expanded to the expected per-cycle outputs
  task automatic build_trace(logic [5:0] pc_rst, int n);
    logic [5:0] p = pc_rst;
    logic [7:0] a = 8'd0;
    logic       c = 1'b0;
    bit         h = 1'b0;
    logic [7:0] w;
    logic [8:0] s;
    q.delete();
    while (q.size() < n) begin
      if (h) begin
        q.push_back(mk(p, 1'b0, a, c, p, 1'b1));
        continue;
      end
      w = rom[p];
      q.push_back(mk(p, 1'b1, a, c, p, 1'b0));
      q.push_back(mk(p, 1'b0, a, c, p, 1'b0));
      if (w[7:6] == 2'b00) begin
        h = 1'b1;
        continue;
      end
      if (w[7:6] == 2'b11) q.push_back(mk(w[5:0], 1'b1, a, c, p, 1'b0));
      q.push_back(mk(p, 1'b0, a, c, p, 1'b0));
      if (w[7:6] == 2'b01) begin
        s = {1'b0, a} + 9'd1;
        {c, a} = s;
      end else if (w[7:6] == 2'b11) begin
        s = {1'b0, a} + {1'b0, rom[w[5:0]]};
        {c, a} = s;
      end
`ifdef CPU_SEQ_JMP_EN
      if (w[7:6] == 2'b10) p = w[5:0];
      else p = 6'((int'(p) + 1) % 64);
`else
      p = 6'((int'(p) + 1) % 64);
`endif
    end
  endtask

  task automatic apply_reset(logic [5:0] pc_rst);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    prev_stb = 1'b0;
    check("reset", mk(pc_rst, 1'b0, 8'd0, 1'b0, pc_rst, 1'b0));
  endtask

  task automatic run_trace(logic [5:0] pc_rst, int n, int id, int abort);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("idle", mk(pc_rst, 1'b0, 8'd0, 1'b0, pc_rst, 1'b0));
    end
    build_trace(pc_rst, n);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("cyc%0d_id%0d", c, id), q[c]);
      if (id == 0) begin
        if (c == 12) lit("inc4_acc", int'(acc0), 4);
        if (c == 16) lit("add1_acc", int'(acc0), 71);
        if (c == 20) lit("add2_acc", int'(acc0), 138);
        if (c == 24) lit("add3_cy", int'({cy0, acc0}), 205);
        if (c == 28) lit("add4_cy_acc", int'({cy0, acc0}), 256 + 16);
        if (c == 30) lit("halt_pc", int'({h0, pc0}), 64 + 8);
        if (c == 14) lit("oprd_addr", int'({rd0, en0, addr0}), 192 + 3);
      end else if (id == 1) begin
        if (c == 3) lit("wrap_pc_acc", int'({pc1, acc1}), 1);
        if (c == 5) lit("wrap_halt", int'({h1, pc1}), 64);
      end else if (id == 2) begin
`ifdef CPU_SEQ_JMP_EN
        if (c == 3) lit("jmp_pc", int'(pc0), 5);
`else
        if (c == 3) lit("nop_pc", int'(pc0), 1);
`endif
        if (c == 5) lit("jmp_halt_acc", int'({h0, acc0}), 256);
      end
      if (c == abort) return;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    foreach (rom[i]) rom[i] = 8'h00;
    for (int i = 0; i < 4; i++) rom[i] = 8'h43;
    for (int i = 4; i < 8; i++) rom[i] = 8'hC3;
    rom[8] = 8'h00;

    sel = 1'b0;
    apply_reset(6'd0);
    run_trace(6'd0, 40, 0, -1);
    apply_reset(6'd0);
    run_trace(6'd0, 40, 0, 14);
    apply_reset(6'd0);
    run_trace(6'd0, 40, 0, -1);

    foreach (rom[i]) rom[i] = 8'h00;
    rom[63] = 8'h40;
    sel = 1'b1;
    apply_reset(6'd63);
    run_trace(6'd63, 10, 1, -1);

    foreach (rom[i]) rom[i] = 8'h00;
    rom[0] = 8'h85;
    sel = 1'b0;
    apply_reset(6'd0);
    run_trace(6'd0, 10, 2, -1);

    for (int r = 0; r < 6; r++) begin
      foreach (rom[i]) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:6] == 2'b00 && $urandom_range(3) != 0) rom[i][7:6] = 2'b11;
      end
      sel = 1'(r % 2);
      apply_reset(sel ? 6'd63 : 6'd0);
      run_trace(sel ? 6'd63 : 6'd0, 150, 3, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
